seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
- Time-multiplexed scanner that sits directly upstream of the 4-bit-to-7-segment hex decoder.
- Holds a NUM_DIGITS-digit hex value and cycles through the digits, presenting one nibble at a time on digit_out for the decoder.
- Drives the common-anode enables in step with the nibble, so a single decoder serves a multi-digit board display.
- Inserts a dead-time between digits so the previous digit's segments do not ghost onto the next one.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (2..8).
- REFRESH_DIV, 100000: clock cycles per digit slot, including dead-time (must be greater than DEAD_CYCLES).
- DEAD_CYCLES, 16: cycles at the start of each slot with all anodes off (at least 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- value_in  in  4*NUM_DIGITS  hex value; digit 0 is bits [3:0].
- load  in  1  single-cycle strobe that captures value_in.
- blank_mask  in  NUM_DIGITS  1 = force that digit dark.
- digit_out  out  4  nibble routed to the decoder input.
- blank_out  out  1  1 = segment driver must be forced off (all segment lines high).
- anode_out  out  NUM_DIGITS  active-low one-hot digit enable.
- digit_idx  out  $clog2(NUM_DIGITS)  index of the current slot.
- frame_start  out  1  one-cycle pulse on the first cycle of slot 0.

Behaviour:
- Reset values (asynchronous, active-high):
  - state=DEAD, digit_idx=0, cycle counter=0.
  - digit_out=4'h0, blank_out=1, anode_out=all 1s, frame_start=0.
  - active and pending registers=0, pending_valid=0.
- All outputs are registered; none is combinational from inputs.
- Cycle counter runs 0..REFRESH_DIV-1 within each slot.
- FSM states:
  - DEAD, counter < DEAD_CYCLES: anode_out all 1s, blank_out=1.
  - ON, the remaining REFRESH_DIV-DEAD_CYCLES cycles:
    - anode_out has bit digit_idx low, all others high.
    - digit_out = active[4*idx +: 4].
    - blank_out=0.
- A digit with blank_mask[idx]=1 stays fully dark during ON: anode_out all 1s, blank_out=1. digit_out still carries the nibble.
- At counter = REFRESH_DIV-1:
  - counter wraps to 0 and state returns to DEAD.
  - digit_idx increments, wrapping NUM_DIGITS-1 to 0.
  - frame_start pulses in the first cycle where digit_idx=0.
- Outputs for a slot reflect digit_idx and state one cycle after the counter transition (one-cycle output register latency).
- Load and tear-free update:
  - load=1 writes value_in into pending and sets pending_valid.
  - active updates only at the frame boundary, i.e. the cycle in which idx wraps to 0.
  - At the boundary, if load=1 that cycle, active <= value_in directly; else if pending_valid, active <= pending. pending_valid then clears.
  - Back-to-back loads within one frame: the last one wins.
- blank_mask is sampled every cycle and needs no boundary alignment.
- Reset mid-scan returns immediately to the reset values. The first slot after reset is digit 0, starting in DEAD.

Optional Feature:
- Macro: SEG_SCAN_LZ_BLANK_EN.
- Defined (leading-zero suppression):
  - Starting from digit NUM_DIGITS-1 and working downward, every digit of active equal to 0 before the first nonzero digit is treated as blanked, exactly like blank_mask=1.
  - Digit 0 is never suppressed.
  - The suppression mask is computed from active, registered, and updated only at the frame boundary.
- Undefined: no suppression logic is present; only blank_mask blanks digits.

Decomposition:
- Package seg_scan_pkg holds:
  - the state enum (DEAD, ON);
  - ANODE_ALL_OFF;
  - the localparam width function for digit_idx.
- One sub-module, seg_scan_timer: the slot cycle counter. It emits dead_end and slot_end strobes. The FSM, registers and output logic stay in seg_scan_mux.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2):
- Reset, then release; no load -> slot 0 dark for cycles 0-1; cycles 2-7 anode_out=4'b1110, digit_out=0, blank_out=0; slot 1 anode_out=4'b1101; frame_start pulses every 32 cycles.
- load=1 with value_in=16'h1A3F mid-frame -> no display change until the next frame_start; then digits show F, 3, A, 1 on anodes 1110, 1101, 1011, 0111.
- load coincident with the boundary cycle, 16'hBEEF, after an earlier pending load of 16'h0000 -> next frame shows F, E, E, B, not 0.
- blank_mask=4'b0100 with value 16'h1234 -> slot 2 keeps anode_out=4'b1111 and blank_out=1; the other slots are unaffected.
- Reset asserted during slot 2 ON -> anode_out=4'b1111, blank_out=1 and digit_idx=0 within the same cycle, without waiting for a clock edge.
- With SEG_SCAN_LZ_BLANK_EN defined, value 16'h0050 -> digits 3 and 2 dark, digits 1 and 0 lit; with 16'h0000 only digit 0 is lit, showing 0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seg_scan_mux display scanner.
package seg_scan_pkg;

    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } state_e;

    // Wide enough for the largest supported board (8 digits); slice to NUM_DIGITS.
    localparam logic [7:0] ANODE_ALL_OFF = 8'hFF;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot cycle counter: runs 0..REFRESH_DIV-1 and flags the last dead cycle and last slot cycle.
module seg_scan_timer #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    output logic o_dead_end,
    output logic o_slot_end
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                r_cnt <= '0;
        else if (r_cnt == SLOT_LAST) r_cnt <= '0;
        else                      r_cnt <= r_cnt + 1'b1;
    end

    assign o_dead_end = (r_cnt == DEAD_LAST);
    assign o_slot_end = (r_cnt == SLOT_LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// Multi-digit hex scanner feeding a single 7-seg decoder, with dead-time between digits.
// Optional leading-zero suppression is built when SEG_SCAN_LZ_BLANK_EN is defined.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [4*NUM_DIGITS-1:0]          value_in,
    input  logic                             load,
    input  logic [NUM_DIGITS-1:0]            blank_mask,
    output logic [3:0]                       digit_out,
    output logic                             blank_out,
    output logic [NUM_DIGITS-1:0]            anode_out,
    output logic [idx_w(NUM_DIGITS)-1:0]     digit_idx,
    output logic                             frame_start
);

    localparam int IW = idx_w(NUM_DIGITS);
    localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AOFF     = ANODE_ALL_OFF[NUM_DIGITS-1:0];

    state_e                    r_state, w_state_nxt;
    logic [IW-1:0]             r_idx;
    logic [4*NUM_DIGITS-1:0]   r_active, r_pending, w_active_nxt;
    logic                      r_pend_vld;
    logic                      w_dead_end, w_slot_end, w_frame_end, w_lit;
    logic [NUM_DIGITS-1:0]     w_lz;

    seg_scan_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .o_dead_end (w_dead_end),
        .o_slot_end (w_slot_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= DEAD;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DEAD:    if (w_dead_end) w_state_nxt = ON;
            ON:      if (w_slot_end) w_state_nxt = DEAD;
            default: w_state_nxt = DEAD;
        endcase
    end

    assign w_frame_end = w_slot_end && (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           r_idx <= '0;
        else if (w_slot_end) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end

    // A load landing on the boundary cycle bypasses pending so it is not lost.
    always_comb begin
        w_active_nxt = r_active;
        if (load)            w_active_nxt = value_in;
        else if (r_pend_vld) w_active_nxt = r_pending;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active   <= '0;
            r_pending  <= '0;
            r_pend_vld <= 1'b0;
        end else if (w_frame_end) begin
            r_active   <= w_active_nxt;
            r_pend_vld <= 1'b0;
        end else if (load) begin
            r_pending  <= value_in;
            r_pend_vld <= 1'b1;
        end
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic                  seen;
        m    = '0;
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (v[4*i +: 4] != 4'h0) seen = 1'b1;
            m[i] = !seen;
        end
        return m;
    endfunction

    logic [NUM_DIGITS-1:0] r_lz;

    // Mask tracks the value going live so it stays aligned with active for the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            r_lz <= lz_mask('0);
        else if (w_frame_end) r_lz <= lz_mask(w_active_nxt);
    end

    assign w_lz = r_lz;
`else
    assign w_lz = '0;
`endif

    assign w_lit = (r_state == ON) && !blank_mask[r_idx] && !w_lz[r_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_out   <= 4'h0;
            blank_out   <= 1'b1;
            anode_out   <= AOFF;
            frame_start <= 1'b0;
        end else begin
            digit_out   <= r_active[4*r_idx +: 4];
            blank_out   <= !w_lit;
            anode_out   <= w_lit ? ~(NUM_DIGITS'(1) << r_idx) : AOFF;
            frame_start <= w_frame_end;
        end
    end

    assign digit_idx = r_idx;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux (4 digits, 8-cycle slots, 2 dead cycles).
module tb_seg_scan_mux;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int DC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_in = '0;
    logic        load = 1'b0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  digit_out;
    logic        blank_out;
    logic [3:0]  anode_out;
    logic [1:0]  digit_idx;
    logic        frame_start;

    seg_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
        .clk         (clk),
        .reset       (reset),
        .value_in    (value_in),
        .load        (load),
        .blank_mask  (blank_mask),
        .digit_out   (digit_out),
        .blank_out   (blank_out),
        .anode_out   (anode_out),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic       bl;
        logic [3:0] dig;
        logic [1:0] idx;
        logic       fs;
        bit         lit;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference state: slot position, digit, shown value, pending load, suppression mask.
    int          m_cnt, m_idx;
    logic [15:0] m_act, m_pend;
    bit          m_pv;
    logic [3:0]  m_lz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] lz_ref(input logic [15:0] v);
        logic [3:0] m;
        int         h;
        m = '0;
`ifdef SEG_SCAN_LZ_BLANK_EN
        h = 0;
        for (int i = 0; i < ND; i++)
            if (v[4*i +: 4] != 4'h0) h = i;
        for (int i = 0; i < ND; i++)
            if (i > h) m[i] = 1'b1;
`else
        h = 0;
        if (v == 16'h0) m = '0;
`endif
        return m;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_idx = 0;
        m_act = '0;
        m_pend = '0;
        m_pv = 0;
        m_lz = lz_ref(16'h0);
    endtask

    // Predict the outputs after the coming edge, advance the model, then compare.
    task automatic tick();
        exp_t e, g;
        bit   on, boundary;
        on       = (m_cnt >= DC) && !blank_mask[m_idx] && !m_lz[m_idx];
        e.an     = on ? ~(4'b0001 << m_idx) : 4'hF;
        e.bl     = !on;
        e.dig    = m_act[4*m_idx +: 4];
        e.fs     = (m_cnt == RD - 1) && (m_idx == ND - 1);
        e.lit    = on;
        boundary = e.fs;
        if (boundary) begin
            if (load)      m_act = value_in;
            else if (m_pv) m_act = m_pend;
            m_pv = 0;
            m_lz = lz_ref(m_act);
        end else if (load) begin
            m_pend = value_in;
            m_pv   = 1;
        end
        if (m_cnt == RD - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % ND;
        end else begin
            m_cnt++;
        end
        e.idx = 2'(m_idx);
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        chk("anode_out", 32'(anode_out), 32'(g.an));
        chk("blank_out", 32'(blank_out), 32'(g.bl));
        chk("digit_idx", 32'(digit_idx), 32'(g.idx));
        chk("frame_start", 32'(frame_start), 32'(g.fs));
        if (g.lit) chk("digit_out", 32'(digit_out), 32'(g.dig));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value_in = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        int guard;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_anode", 32'(anode_out), 32'hF);
        chk("rst_blank", 32'(blank_out), 32'h1);
        chk("rst_digit", 32'(digit_out), 32'h0);
        chk("rst_idx", 32'(digit_idx), 32'h0);
        chk("rst_fs", 32'(frame_start), 32'h0);
        reset = 1'b0;

        // idle scan of zeros, then a mid-frame load that must wait for the boundary
        run(64);
        run(10);
        pulse_load(16'h1A3F);
        run(70);

        // stale pending 0000 must lose to a load on the boundary cycle itself
        pulse_load(16'h0000);
        guard = 0;
        while (!(m_cnt == RD - 1 && m_idx == ND - 1) && guard < 64) begin
            tick();
            guard++;
        end
        chk("boundary_reached", 32'(guard < 64), 32'h1);
        pulse_load(16'hBEEF);
        run(40);

        blank_mask = 4'b0100;
        pulse_load(16'h1234);
        run(70);
        blank_mask = 4'b0000;
        run(8);

        // asynchronous reset in the middle of slot 2's lit phase
        guard = 0;
        while (!(m_idx == 2 && m_cnt == 5) && guard < 64) begin
            tick();
            guard++;
        end
        chk("slot2_lit_before_rst", 32'(anode_out), 32'hB);
        reset = 1'b1;
        #1;
        chk("async_rst_anode", 32'(anode_out), 32'hF);
        chk("async_rst_blank", 32'(blank_out), 32'h1);
        chk("async_rst_idx", 32'(digit_idx), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        run(40);

        pulse_load(16'h0050);
        run(70);
        pulse_load(16'h0000);
        run(70);

        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
